// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum frame reader: word geometry, framing
// markers, FSM state encoding and the checksum helper.
package spectrum_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  localparam logic [HALF_W-1:0] SYNC_HDR_DEF = 16'hA5A5;
  localparam logic [HALF_W-1:0] SYNC_TRL_DEF = 16'h5A5A;
  localparam logic [HALF_W-1:0] BIN_MARK     = 16'hB1B1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BIN_HDR,
    ST_PAYLOAD,
    ST_TRL
  } state_t;

  // Sum of the two spectral points packed in one FIFO word, modulo 2^16.
  function automatic logic [HALF_W-1:0] half_sum(input logic [WORD_W-1:0] w);
    return w[WORD_W-1:HALF_W] + w[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/spectrum_skid_buf.sv
// Two-entry valid/ready buffer between the spectrum FIFO read port and the
// output register. It soaks up the one-cycle FIFO read latency plus one word
// of downstream backpressure. The writer must never push while full; the
// reader's credit logic uses level_o to guarantee that.
module spectrum_skid_buf
  import spectrum_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   level_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   level_q;
  logic         push;
  logic         pop;

  assign push        = in_valid_i && (level_q != 2'd2);
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (level_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign level_o     = level_q;

  // Storage: data needs no reset, occupancy alone says what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 2'd1;
        2'b01:   level_q <= level_q - 2'd1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/spectrum_frame_reader.sv
// Read side of the spectrum FIFO. Each completed accumulation produces one
// frame on y0_o/y0z_o: header, then per range bin a bin marker followed by
// WORDS_PER_BIN payload words, then a trailer carrying a 16-bit checksum.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for frame_ready_i or a pending request
// ST_HDR     | emitting {SYNC_HDR, frame_cnt}
// ST_BIN_HDR | emitting {BIN_MARK, bin}
// ST_PAYLOAD | reading FIFO words through the skid buffer to the output
// ST_TRL     | emitting {SYNC_TRL, checksum}, bumping the frame counter
//
// A state moves on as soon as its word enters the output register, which
// happens whenever that register is empty or being accepted this cycle, so
// words stream back to back under continuous out_ready_i.
module spectrum_frame_reader
  import spectrum_pkg::*;
#(
  parameter int          WORDS_PER_BIN = 256,
  parameter int          MAX_BINS      = 64,
  parameter logic [15:0] SYNC_HDR      = SYNC_HDR_DEF,
  parameter logic [15:0] SYNC_TRL      = SYNC_TRL_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                frame_ready_i,
  input  logic [15:0]         n_range_bins_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_en_o,
  input  logic [WORD_W-1:0]   fifo_dout_i,
  input  logic                out_ready_i,
  output logic [HALF_W-1:0]   y0_o,
  output logic [HALF_W-1:0]   y0z_o,
  output logic                data_valid_o,
  output logic                frame_start_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int CNT_W = $clog2(WORDS_PER_BIN + 1);
  localparam int NB_W  = $clog2(MAX_BINS + 1);

  state_t             state_q;
  logic [NB_W-1:0]    nb_q;
  logic [NB_W-1:0]    bin_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic [CNT_W-1:0]   em_cnt_q;
  logic [15:0]        frame_cnt_q;
  logic [HALF_W-1:0]  cksum_q;
  logic               pending_q;
  logic               rd_q;

  logic               buf_valid;
  logic [WORD_W-1:0]  buf_data;
  logic [1:0]         buf_level;
  logic               buf_pop;

  logic               out_slot;
  logic               in_payload;
  logic [2:0]         occupancy;
  logic               rd_space;
  logic [NB_W-1:0]    nb_clamped;
  logic               last_bin;
  logic               last_word;
  logic               start;

  // Output register can take a new word if empty or drained this cycle.
  assign out_slot   = !data_valid_o || out_ready_i;
  assign in_payload = (state_q == ST_PAYLOAD);
  assign buf_pop    = in_payload && out_slot && buf_valid;

  // Credit check: stored words plus the one in flight from the FIFO, less
  // the one leaving this cycle, must leave room for a new read result.
  assign occupancy = 3'(buf_level) + 3'(rd_q);
  assign rd_space  = buf_pop ? (occupancy < 3'd3) : (occupancy < 3'd2);

  assign fifo_rd_en_o = in_payload && !fifo_empty_i && rd_space &&
                        (rd_cnt_q != CNT_W'(WORDS_PER_BIN));

  assign busy_o = (state_q != ST_IDLE);

  assign nb_clamped = (n_range_bins_i > 16'(MAX_BINS)) ? NB_W'(MAX_BINS)
                                                       : n_range_bins_i[NB_W-1:0];
  assign last_bin   = (bin_q == nb_q - NB_W'(1));
  assign last_word  = (em_cnt_q == CNT_W'(WORDS_PER_BIN - 1));
  assign start      = frame_ready_i || pending_q;

  spectrum_skid_buf #(
    .W (WORD_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (rd_q),
    .in_data_i   (fifo_dout_i),
    .out_valid_o (buf_valid),
    .out_data_o  (buf_data),
    .out_ready_i (buf_pop),
    .level_o     (buf_level)
  );

  // Marks the cycle in which FIFO read data is valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= fifo_rd_en_o;
    end
  end

  // Framing FSM with counters, checksum, request queueing and output register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      nb_q          <= '0;
      bin_q         <= '0;
      rd_cnt_q      <= '0;
      em_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      cksum_q       <= '0;
      pending_q     <= 1'b0;
      overrun_o     <= 1'b0;
      y0_o          <= '0;
      y0z_o         <= '0;
      data_valid_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      if (out_ready_i) begin
        data_valid_o  <= 1'b0;
        frame_start_o <= 1'b0;
      end

      // One request can wait behind the running frame; a second one is lost.
      if (state_q != ST_IDLE && frame_ready_i) begin
        if (pending_q) begin
          overrun_o <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            nb_q      <= nb_clamped;
            cksum_q   <= '0;
            // A fresh pulse arriving as the pending one is consumed stays queued.
            pending_q <= pending_q && frame_ready_i;
            state_q   <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (out_slot) begin
            y0_o          <= SYNC_HDR;
            y0z_o         <= frame_cnt_q;
            data_valid_o  <= 1'b1;
            frame_start_o <= 1'b1;
            bin_q         <= '0;
            state_q       <= (nb_q == '0) ? ST_TRL : ST_BIN_HDR;
          end
        end

        ST_BIN_HDR: begin
          if (out_slot) begin
            y0_o          <= BIN_MARK;
            y0z_o         <= HALF_W'(bin_q);
            data_valid_o  <= 1'b1;
            frame_start_o <= 1'b0;
            rd_cnt_q      <= '0;
            em_cnt_q      <= '0;
            state_q       <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (fifo_rd_en_o) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
          if (buf_pop) begin
            y0_o          <= buf_data[WORD_W-1:HALF_W];
            y0z_o         <= buf_data[HALF_W-1:0];
            data_valid_o  <= 1'b1;
            frame_start_o <= 1'b0;
            cksum_q       <= cksum_q + half_sum(buf_data);
            em_cnt_q      <= em_cnt_q + CNT_W'(1);
            if (last_word) begin
              bin_q   <= bin_q + NB_W'(1);
              state_q <= last_bin ? ST_TRL : ST_BIN_HDR;
            end
          end
        end

        ST_TRL: begin
          if (out_slot) begin
            y0_o          <= SYNC_TRL;
            y0z_o         <= cksum_q;
            data_valid_o  <= 1'b1;
            frame_start_o <= 1'b0;
            frame_cnt_q   <= frame_cnt_q + 16'd1;
            state_q       <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_frame_reader.sv
// Self-checking bench for spectrum_frame_reader with a small FIFO model and
// an expected-word scoreboard.
module tb_spectrum_frame_reader;

  localparam int WPB  = 4;
  localparam int MAXB = 64;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        frame_ready_i;
  logic [15:0] n_range_bins_i;
  logic        fifo_empty_i;
  logic        fifo_rd_en_o;
  logic [31:0] fifo_dout_i = '0;
  logic        out_ready_i;
  logic [15:0] y0_o;
  logic [15:0] y0z_o;
  logic        data_valid_o;
  logic        frame_start_o;
  logic        busy_o;
  logic        overrun_o;

  spectrum_frame_reader #(
    .WORDS_PER_BIN (WPB),
    .MAX_BINS      (MAXB)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .frame_ready_i  (frame_ready_i),
    .n_range_bins_i (n_range_bins_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .fifo_dout_i    (fifo_dout_i),
    .out_ready_i    (out_ready_i),
    .y0_o           (y0_o),
    .y0z_o          (y0z_o),
    .data_valid_o   (data_valid_o),
    .frame_start_o  (frame_start_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: data appears on fifo_dout_i the cycle after a read strobe.
  logic [31:0] fmem [0:1023];
  int wr_ptr   = 0;
  int rd_ptr   = 0;
  int rd_total = 0;
  int bad_rd   = 0;

  assign fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk_i) begin
    if (fifo_rd_en_o) begin
      rd_total <= rd_total + 1;
      if (fifo_empty_i || !busy_o) bad_rd <= bad_rd + 1;
      if (!fifo_empty_i) begin
        fifo_dout_i <= fmem[rd_ptr];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  typedef struct packed {
    logic [31:0] word;
    logic        fs;
  } exp_t;

  typedef struct {
    logic [15:0] nbins;
    int          mode;      // 0 plain, 1 FIFO gap, 2 random out_ready_i
    int          exp_len;
    logic [15:0] exp_cks;
    logic [15:0] exp_fcnt;
    int          exp_rds;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  int          rx_cnt = 0;
  int          hdr_cnt = 0;
  logic [31:0] last_word = '0;
  logic [31:0] hdr_word = '0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_word = '0;
  logic        hold_fs = 1'b0;
  logic        rand_ready = 1'b0;
  logic [15:0] fcnt_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor, sampled at the falling edge.
  task automatic monitor();
    exp_t e;
    if (!rst_i) begin
      hold_valid = 1'b0;
      return;
    end
    if (hold_valid) begin
      check("stall_valid", 32'(data_valid_o), 32'd1);
      check("stall_data", {y0_o, y0z_o}, hold_word);
      check("stall_fs", 32'(frame_start_o), 32'(hold_fs));
    end
    if (data_valid_o && out_ready_i) begin
      rx_cnt++;
      last_word = {y0_o, y0z_o};
      if (frame_start_o) begin
        hdr_cnt++;
        hdr_word = {y0_o, y0z_o};
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_word: got %h expected no word", {y0_o, y0z_o});
      end else begin
        e = exp_q.pop_front();
        check("sb_word", {y0_o, y0z_o}, e.word);
        check("sb_fs", 32'(frame_start_o), 32'(e.fs));
      end
      hold_valid = 1'b0;
    end else begin
      hold_valid = data_valid_o;
      hold_word  = {y0_o, y0z_o};
      hold_fs    = frame_start_o;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #2;
    if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic preload(input int k0, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = {16'(2 * (k0 + i) + 1), 16'(2 * (k0 + i) + 2)};
      wr_ptr++;
    end
  endtask

  task automatic push_frame(input int nb, input logic [15:0] fc);
    logic [15:0] cks;
    logic [15:0] hi;
    logic [15:0] lo;
    int          k;
    exp_q.push_back('{word: {16'hA5A5, fc}, fs: 1'b1});
    cks = '0;
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back('{word: {16'hB1B1, 16'(b)}, fs: 1'b0});
      for (int w = 0; w < WPB; w++) begin
        k  = b * WPB + w;
        hi = 16'(2 * k + 1);
        lo = 16'(2 * k + 2);
        exp_q.push_back('{word: {hi, lo}, fs: 1'b0});
        cks = cks + hi + lo;
      end
    end
    exp_q.push_back('{word: {16'h5A5A, cks}, fs: 1'b0});
  endtask

  task automatic pulse();
    frame_ready_i = 1'b1;
    tick();
    frame_ready_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o || data_valid_o) && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_fifo_drained();
    int n = 0;
    while (rd_ptr != wr_ptr && n < 200) begin
      tick();
      n++;
    end
    check("fifo_drain_wait", 32'(n < 200), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   nbm;
    int   rds0;

    rst_i          = 1'b0;
    frame_ready_i  = 1'b0;
    n_range_bins_i = '0;
    out_ready_i    = 1'b1;

    vecs[0] = '{nbins: 16'd2,   mode: 0, exp_len: 12,  exp_cks: 16'h0088, exp_fcnt: 16'd0, exp_rds: 8};
    vecs[1] = '{nbins: 16'd0,   mode: 0, exp_len: 2,   exp_cks: 16'h0000, exp_fcnt: 16'd1, exp_rds: 0};
    vecs[2] = '{nbins: 16'd1,   mode: 1, exp_len: 7,   exp_cks: 16'h0024, exp_fcnt: 16'd2, exp_rds: 4};
    vecs[3] = '{nbins: 16'd2,   mode: 2, exp_len: 12,  exp_cks: 16'h0088, exp_fcnt: 16'd3, exp_rds: 8};
    vecs[4] = '{nbins: 16'd100, mode: 0, exp_len: 322, exp_cks: 16'h0100, exp_fcnt: 16'd4, exp_rds: 256};

    #1;
    check("reset_data", {y0_o, y0z_o}, 32'd0);
    check("reset_flags", 32'({data_valid_o, frame_start_o, busy_o, overrun_o, fifo_rd_en_o}), 32'd0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      v   = vecs[i];
      nbm = (v.nbins > 16'(MAXB)) ? MAXB : int'(v.nbins);
      n_range_bins_i = v.nbins;
      rx_cnt = 0;
      rds0   = rd_total;
      if (v.mode == 1) preload(0, 2);
      else             preload(0, nbm * WPB);
      push_frame(nbm, fcnt_m);
      if (v.mode == 2) rand_ready = 1'b1;

      frame_ready_i = 1'b1;
      tick();
      frame_ready_i  = 1'b0;
      n_range_bins_i = 16'd3;
      check("latency_n1_idle", 32'(data_valid_o), 32'd0);
      tick();
      check("latency_n2_hdr", 32'({data_valid_o, frame_start_o}), 32'd3);

      if (v.mode == 1) begin
        wait_fifo_drained();
        repeat (10) tick();
        check("gap_idle", 32'({data_valid_o, fifo_rd_en_o}), 32'd0);
        preload(2, 2);
      end

      wait_done("frame_done");
      rand_ready  = 1'b0;
      out_ready_i = 1'b1;
      check("frame_len", 32'(rx_cnt), 32'(v.exp_len));
      check("trl_sync", 32'(last_word[31:16]), 32'h5A5A);
      check("trl_cksum", 32'(last_word[15:0]), 32'(v.exp_cks));
      check("hdr_fcnt", 32'(hdr_word[15:0]), 32'(v.exp_fcnt));
      check("fifo_reads", 32'(rd_total - rds0), 32'(v.exp_rds));
      fcnt_m = fcnt_m + 16'd1;
      tick();
    end

    // Three requests in one frame: one runs, one waits, one is dropped.
    n_range_bins_i = 16'd1;
    preload(0, 4);
    preload(0, 4);
    rx_cnt  = 0;
    hdr_cnt = 0;
    push_frame(1, fcnt_m);
    push_frame(1, fcnt_m + 16'd1);
    pulse();
    tick();
    tick();
    pulse();
    check("overrun_after_2", 32'(overrun_o), 32'd0);
    tick();
    pulse();
    check("overrun_after_3", 32'(overrun_o), 32'd1);
    wait_done("b2b_done");
    check("b2b_frames", 32'(hdr_cnt), 32'd2);
    check("b2b_words", 32'(rx_cnt), 32'd14);
    check("overrun_sticky", 32'(overrun_o), 32'd1);
    fcnt_m = fcnt_m + 16'd2;
    tick();

    // Reset while stalled mid-payload on an empty FIFO.
    n_range_bins_i = 16'd1;
    preload(0, 2);
    push_frame(1, fcnt_m);
    pulse();
    wait_fifo_drained();
    repeat (6) tick();
    check("stalled_busy", 32'(busy_o), 32'd1);
    #1 rst_i = 1'b0;
    #1;
    check("midreset_data", {y0_o, y0z_o}, 32'd0);
    check("midreset_flags", 32'({data_valid_o, frame_start_o, busy_o, overrun_o, fifo_rd_en_o}), 32'd0);
    exp_q.delete();
    fcnt_m = '0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    preload(0, 4);
    push_frame(1, fcnt_m);
    rx_cnt = 0;
    pulse();
    wait_done("post_reset_done");
    check("post_reset_hdr", hdr_word, 32'hA5A50000);
    check("post_reset_len", 32'(rx_cnt), 32'd7);

    check("rd_en_legal", 32'(bad_rd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
